// File: rtl/jtag_tap_param_if.sv
// JTAG pin bundle between a tester (master) and the TAP (slave).
// Latency: none (wires only).
// Backpressure: none; TMS/TDI are sampled on rising TCK, TDO/TDO_EN change on falling TCK.
//
// Signals: TMS, TDI  tester -> TAP
//          TDO, TDO_EN  TAP -> tester (TDO_EN drives the pad output enable)
interface jtag_tap_param_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic TDO_EN;

    modport master (
        output TMS,
        output TDI,
        input  TDO,
        input  TDO_EN
    );

    modport slave (
        input  TMS,
        input  TDI,
        output TDO,
        output TDO_EN
    );
endinterface

// File: rtl/jtag_tap_param.sv
// Parametrised IEEE 1149.1 TAP: 16-state controller, IR, BYPASS, IDCODE, SAMPLE/PRELOAD, EXTEST.
// Latency: first TDO bit on the falling TCK after entering Shift-IR/DR; N posedges shift N bits.
// Backpressure: none; the tester paces everything through TCK/TMS.
//
// Optional feature: define JTAG_USERCODE_EN to add the 32-bit USERCODE register
// (selected by OP_USERCODE). Without it OP_USERCODE decodes as BYPASS.
//
// Ports:
//   TCK, TRST_N   test clock and asynchronous active-low reset
//   jtag          TMS/TDI in, TDO/TDO_EN out (TDO/TDO_EN registered on falling TCK)
//   STATE         current TAP state code
//   IR_OUT        active instruction
//   BSR_IN        pin/core values captured in Capture-DR
//   BSR_OUT       boundary update register, loaded in Update-DR for SAMPLE/EXTEST
//   EXTEST_MODE   high while the active instruction is EXTEST
module jtag_tap_param #(
    parameter int                     IR_WIDTH     = 4,
    parameter int                     BSR_LEN      = 10,
    parameter logic [31:0]            IDCODE_VAL   = 32'h1234_5001,
    parameter logic [31:0]            USERCODE_VAL = 32'h0000_00A5,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE    = IR_WIDTH'(7),
    parameter logic [IR_WIDTH-1:0]    OP_SAMPLE    = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]    OP_EXTEST    = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0]    OP_USERCODE  = IR_WIDTH'(8)
) (
    input  logic                 TCK,
    input  logic                 TRST_N,
    jtag_tap_param_if.slave      jtag,
    output logic [3:0]           STATE,
    output logic [IR_WIDTH-1:0]  IR_OUT,
    input  logic [BSR_LEN-1:0]   BSR_IN,
    output logic [BSR_LEN-1:0]   BSR_OUT,
    output logic                 EXTEST_MODE
);

    // State codes follow the standard 1149.1 encoding so STATE can be
    // compared directly with external analysers.
    typedef enum logic [3:0] {
        S_EX2DR = 4'h0,
        S_EX1DR = 4'h1,
        S_SHDR  = 4'h2,
        S_PDR   = 4'h3,
        S_SELIR = 4'h4,
        S_UPDR  = 4'h5,
        S_CAPDR = 4'h6,
        S_SELDR = 4'h7,
        S_EX2IR = 4'h8,
        S_EX1IR = 4'h9,
        S_SHIR  = 4'hA,
        S_PIR   = 4'hB,
        S_RTI   = 4'hC,
        S_UPIR  = 4'hD,
        S_CAPIR = 4'hE,
        S_TLR   = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_BSR    = 2'd2,
        DR_USER   = 2'd3
    } dr_sel_t;

    // The mandatory 1149.1 IR capture pattern: LSBs 01, zeros above.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t            state;
    tap_state_t            state_nxt;
    dr_sel_t               dr_sel;

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [31:0]           id_sr;
    logic [BSR_LEN-1:0]    bsr_sr;
    logic [BSR_LEN-1:0]    bsr_shift;
    logic                  byp_sr;
    logic                  tdo_nxt;
    logic                  tdo_en_nxt;

    //------------------------------------------------------------------
    // TAP controller
    //------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state <= S_TLR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_TLR:   state_nxt = jtag.TMS ? S_TLR   : S_RTI;
            S_RTI:   state_nxt = jtag.TMS ? S_SELDR : S_RTI;
            S_SELDR: state_nxt = jtag.TMS ? S_SELIR : S_CAPDR;
            S_CAPDR: state_nxt = jtag.TMS ? S_EX1DR : S_SHDR;
            S_SHDR:  state_nxt = jtag.TMS ? S_EX1DR : S_SHDR;
            S_EX1DR: state_nxt = jtag.TMS ? S_UPDR  : S_PDR;
            S_PDR:   state_nxt = jtag.TMS ? S_EX2DR : S_PDR;
            S_EX2DR: state_nxt = jtag.TMS ? S_UPDR  : S_SHDR;
            S_UPDR:  state_nxt = jtag.TMS ? S_SELDR : S_RTI;
            S_SELIR: state_nxt = jtag.TMS ? S_TLR   : S_CAPIR;
            S_CAPIR: state_nxt = jtag.TMS ? S_EX1IR : S_SHIR;
            S_SHIR:  state_nxt = jtag.TMS ? S_EX1IR : S_SHIR;
            S_EX1IR: state_nxt = jtag.TMS ? S_UPIR  : S_PIR;
            S_PIR:   state_nxt = jtag.TMS ? S_EX2IR : S_PIR;
            S_EX2IR: state_nxt = jtag.TMS ? S_UPIR  : S_SHIR;
            S_UPIR:  state_nxt = jtag.TMS ? S_SELDR : S_RTI;
            default: state_nxt = S_TLR;
        endcase
    end

    assign STATE = state;

    //------------------------------------------------------------------
    // Instruction register
    //------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr <= '0;
        end else if (state == S_CAPIR) begin
            ir_sr <= IR_CAPTURE;
        end else if (state == S_SHIR) begin
            ir_sr <= {jtag.TDI, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // TLR keeps forcing IDCODE so a 5xTMS=1 escape always restores a known IR.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            IR_OUT <= OP_IDCODE;
        end else if (state == S_TLR) begin
            IR_OUT <= OP_IDCODE;
        end else if (state == S_UPIR) begin
            IR_OUT <= ir_sr;
        end
    end

    assign EXTEST_MODE = (IR_OUT == OP_EXTEST);

    //------------------------------------------------------------------
    // Data register select; IDCODE wins if opcodes ever overlap
    //------------------------------------------------------------------
    always_comb begin
        dr_sel = DR_BYPASS;
        if (IR_OUT == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if ((IR_OUT == OP_SAMPLE) || (IR_OUT == OP_EXTEST)) begin
            dr_sel = DR_BSR;
        end
`ifdef JTAG_USERCODE_EN
        else if (IR_OUT == OP_USERCODE) begin
            dr_sel = DR_USER;
        end
`endif
    end

    //------------------------------------------------------------------
    // Data registers: all capture together, only the selected one shifts
    //------------------------------------------------------------------
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            id_sr <= '0;
        end else if (state == S_CAPDR) begin
            id_sr <= IDCODE_VAL;
        end else if ((state == S_SHDR) && (dr_sel == DR_IDCODE)) begin
            id_sr <= {jtag.TDI, id_sr[31:1]};
        end
    end

    // Shift through a widened copy so a single-cell chain needs no special case.
    assign bsr_shift = BSR_LEN'({jtag.TDI, bsr_sr} >> 1);

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bsr_sr <= '0;
        end else if (state == S_CAPDR) begin
            bsr_sr <= BSR_IN;
        end else if ((state == S_SHDR) && (dr_sel == DR_BSR)) begin
            bsr_sr <= bsr_shift;
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            byp_sr <= 1'b0;
        end else if (state == S_CAPDR) begin
            byp_sr <= 1'b0;
        end else if ((state == S_SHDR) && (dr_sel == DR_BYPASS)) begin
            byp_sr <= jtag.TDI;
        end
    end

    // Update stage only moves for boundary-scan instructions; any other
    // instruction leaves the pins exactly as they were.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            BSR_OUT <= '0;
        end else if ((state == S_UPDR) && (dr_sel == DR_BSR)) begin
            BSR_OUT <= bsr_sr;
        end
    end

`ifdef JTAG_USERCODE_EN
    logic [31:0] uc_sr;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            uc_sr <= '0;
        end else if (state == S_CAPDR) begin
            uc_sr <= USERCODE_VAL;
        end else if ((state == S_SHDR) && (dr_sel == DR_USER)) begin
            uc_sr <= {jtag.TDI, uc_sr[31:1]};
        end
    end
`else
    // USERCODE register absent in this build; keep its parameters referenced.
    logic unused_uc;
    assign unused_uc = ^{USERCODE_VAL, OP_USERCODE};
`endif

    //------------------------------------------------------------------
    // TDO path: registered on the falling edge so the pin is stable
    // around the tester's rising-edge sample.
    //------------------------------------------------------------------
    always_comb begin
        tdo_nxt    = 1'b0;
        tdo_en_nxt = 1'b0;
        if (state == S_SHIR) begin
            tdo_en_nxt = 1'b1;
            tdo_nxt    = ir_sr[0];
        end else if (state == S_SHDR) begin
            tdo_en_nxt = 1'b1;
            unique case (dr_sel)
                DR_IDCODE: tdo_nxt = id_sr[0];
                DR_BSR:    tdo_nxt = bsr_sr[0];
`ifdef JTAG_USERCODE_EN
                DR_USER:   tdo_nxt = uc_sr[0];
`endif
                default:   tdo_nxt = byp_sr;
            endcase
        end
    end

    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            jtag.TDO    <= 1'b0;
            jtag.TDO_EN <= 1'b0;
        end else begin
            jtag.TDO    <= tdo_nxt;
            jtag.TDO_EN <= tdo_en_nxt;
        end
    end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Self-checking bench for jtag_tap_param: spec-level TAP model plus directed scans.
// Latency: model advances on each rising TCK, outputs compared 1 time unit after each falling TCK.
// Backpressure: none; the bench drives TMS/TDI freely.
module tb_jtag_tap_param;
    localparam int          IRW  = 4;
    localparam int          BL   = 10;
    localparam logic [31:0] IDV  = 32'h1234_5001;
    localparam logic [31:0] UCV  = 32'h0000_00A5;
    localparam logic [IRW-1:0] OPID = 4'd7;
    localparam logic [IRW-1:0] OPSP = 4'd1;
    localparam logic [IRW-1:0] OPEX = 4'd2;
    localparam logic [IRW-1:0] OPUC = 4'd8;

    localparam logic [3:0] T_EX2DR = 4'h0, T_EX1DR = 4'h1, T_SHDR = 4'h2, T_PDR = 4'h3;
    localparam logic [3:0] T_SELIR = 4'h4, T_UPDR = 4'h5, T_CAPDR = 4'h6, T_SELDR = 4'h7;
    localparam logic [3:0] T_EX2IR = 4'h8, T_EX1IR = 4'h9, T_SHIR = 4'hA, T_PIR = 4'hB;
    localparam logic [3:0] T_RTI = 4'hC, T_UPIR = 4'hD, T_CAPIR = 4'hE, T_TLR = 4'hF;

    logic           TCK = 1'b0;
    logic           TRST_N;
    logic [3:0]     STATE;
    logic [IRW-1:0] IR_OUT;
    logic [BL-1:0]  BSR_IN;
    logic [BL-1:0]  BSR_OUT;
    logic           EXTEST_MODE;

    jtag_tap_param_if jif ();

    jtag_tap_param dut (
        .TCK         (TCK),
        .TRST_N      (TRST_N),
        .jtag        (jif.slave),
        .STATE       (STATE),
        .IR_OUT      (IR_OUT),
        .BSR_IN      (BSR_IN),
        .BSR_OUT     (BSR_OUT),
        .EXTEST_MODE (EXTEST_MODE)
    );

    always #5 TCK = ~TCK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]     nx0 [16];
    logic [3:0]     nx1 [16];
    logic [3:0]     m_state;
    logic [IRW-1:0] m_ir_sr, m_ir_out;
    logic [31:0]    m_id, m_uc;
    logic [BL-1:0]  m_bsr, m_bsr_out;
    logic           m_byp, m_tdo, m_tdo_en;

    task automatic arc(input logic [3:0] s, input logic [3:0] on0, input logic [3:0] on1);
        nx0[s] = on0;
        nx1[s] = on1;
    endtask

    task automatic init_table();
        arc(T_TLR,   T_RTI,   T_TLR);
        arc(T_RTI,   T_RTI,   T_SELDR);
        arc(T_SELDR, T_CAPDR, T_SELIR);
        arc(T_CAPDR, T_SHDR,  T_EX1DR);
        arc(T_SHDR,  T_SHDR,  T_EX1DR);
        arc(T_EX1DR, T_PDR,   T_UPDR);
        arc(T_PDR,   T_PDR,   T_EX2DR);
        arc(T_EX2DR, T_SHDR,  T_UPDR);
        arc(T_UPDR,  T_RTI,   T_SELDR);
        arc(T_SELIR, T_CAPIR, T_TLR);
        arc(T_CAPIR, T_SHIR,  T_EX1IR);
        arc(T_SHIR,  T_SHIR,  T_EX1IR);
        arc(T_EX1IR, T_PIR,   T_UPIR);
        arc(T_PIR,   T_PIR,   T_EX2IR);
        arc(T_EX2IR, T_SHIR,  T_UPIR);
        arc(T_UPIR,  T_RTI,   T_SELDR);
    endtask

    // 0 bypass, 1 idcode, 2 boundary, 3 usercode
    function automatic int m_sel(input logic [IRW-1:0] ir);
        if (ir == OPID) return 1;
        if (ir == OPSP || ir == OPEX) return 2;
`ifdef JTAG_USERCODE_EN
        if (ir == OPUC) return 3;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_state = T_TLR; m_ir_out = OPID; m_ir_sr = '0;
        m_id = '0; m_uc = '0; m_bsr = '0; m_byp = 1'b0;
        m_bsr_out = '0; m_tdo = 1'b0; m_tdo_en = 1'b0;
    endtask

    task automatic model_step(input logic tms, input logic tdi);
        logic [3:0] p;
        int sel;
        p   = m_state;
        sel = m_sel(m_ir_out);
        case (p)
            T_TLR:   m_ir_out = OPID;
            T_CAPIR: m_ir_sr = IRW'(1);
            T_SHIR:  m_ir_sr = (m_ir_sr >> 1) | (IRW'(tdi) << (IRW - 1));
            T_UPIR:  m_ir_out = m_ir_sr;
            T_CAPDR: begin m_id = IDV; m_uc = UCV; m_bsr = BSR_IN; m_byp = 1'b0; end
            T_SHDR: begin
                if (sel == 0) m_byp = tdi;
                else if (sel == 1) m_id = (m_id >> 1) | (32'(tdi) << 31);
                else if (sel == 2) m_bsr = (m_bsr >> 1) | (BL'(tdi) << (BL - 1));
                else m_uc = (m_uc >> 1) | (32'(tdi) << 31);
            end
            T_UPDR:  if (sel == 2) m_bsr_out = m_bsr;
            default: ;
        endcase
        m_state = tms ? nx1[p] : nx0[p];
        sel = m_sel(m_ir_out);
        m_tdo_en = (m_state == T_SHIR) || (m_state == T_SHDR);
        if (m_state == T_SHIR) m_tdo = m_ir_sr[0];
        else if (m_state == T_SHDR)
            m_tdo = (sel == 1) ? m_id[0] : (sel == 2) ? m_bsr[0] : (sel == 3) ? m_uc[0] : m_byp;
        else m_tdo = 1'b0;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge TCK) begin
        #1;
        if (chk_en) begin
            check("state",   64'(STATE),       64'(m_state));
            check("ir_out",  64'(IR_OUT),      64'(m_ir_out));
            check("bsr_out", 64'(BSR_OUT),     64'(m_bsr_out));
            check("extest",  64'(EXTEST_MODE), 64'(m_ir_out == OPEX));
            check("tdo_en",  64'(jif.TDO_EN),  64'(m_tdo_en));
            check("tdo",     64'(jif.TDO),     64'(m_tdo));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at falling edge + 2; returns at the next falling edge + 2.
    task automatic tick(input logic tms, input logic tdi);
        jif.TMS = tms;
        jif.TDI = tdi;
        @(posedge TCK);
        if (TRST_N) model_step(tms, tdi);
        @(negedge TCK);
        #2;
    endtask

    task automatic shift_ir(input logic [IRW-1:0] v, output logic [IRW-1:0] o);
        o = '0;
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IRW; i++) begin
            o[i] = jif.TDO;
            tick(i == IRW - 1, v[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic shift_dr(input int n, input logic [63:0] v, output logic [63:0] o);
        o = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < n; i++) begin
            o[i] = jif.TDO;
            tick(i == n - 1, v[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    logic [IRW-1:0] iro;
    logic [63:0]    dro;
    logic [BL-1:0]  pv;
    logic [BL-1:0]  pin;

    initial begin
        init_table();
        jif.TMS = 1'b1;
        jif.TDI = 1'b0;
        BSR_IN  = '0;
        TRST_N  = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(negedge TCK); #2;
        TRST_N = 1'b1;

        // Reset then one TMS=0
        tick(0, 0);
        check("rst_state",  64'(STATE),      64'hC);
        check("rst_ir",     64'(IR_OUT),     64'h7);
        check("rst_tdo_en", 64'(jif.TDO_EN), 64'h0);
        check("rst_bsr",    64'(BSR_OUT),    64'h0);

        // IDCODE
        shift_dr(32, 64'h0, dro);
        check("idcode", dro[31:0], 64'h1234_5001);

        // IR capture pattern, then BYPASS
        shift_ir(4'hF, iro);
        check("ir_capture", 64'(iro), 64'h1);
        check("ir_bypass",  64'(IR_OUT), 64'hF);
        shift_dr(8, 64'h55, dro);
        check("bypass", dro[7:0], 64'hAA);

        // Enter Shift-DR, escape with five TMS=1, IDCODE restored
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("tlr_escape", 64'(STATE), 64'hF);
        tick(0, 0);
        check("tlr_ir", 64'(IR_OUT), 64'h7);
        shift_dr(32, 64'h0, dro);
        check("idcode2", dro[31:0], 64'h1234_5001);

        // SAMPLE/PRELOAD then EXTEST
        BSR_IN = 10'h2A5;
        shift_ir(4'h1, iro);
        shift_dr(BL, 64'h3C3, dro);
        check("sample_cap", dro[BL-1:0], 64'h2A5);
        check("sample_upd", 64'(BSR_OUT), 64'h3C3);
        check("sample_noext", 64'(EXTEST_MODE), 64'h0);
        shift_ir(4'h2, iro);
        check("extest_mode", 64'(EXTEST_MODE), 64'h1);
        check("extest_hold", 64'(BSR_OUT), 64'h3C3);

        // Paused shift: 3 bits, Pause-DR x4, Exit2, 7 more bits
        BSR_IN = 10'h15A;
        pin = 10'h0F1;
        pv = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        check("shdr_tdo_en", 64'(jif.TDO_EN), 64'h1);
        for (int i = 0; i < 3; i++) begin
            pv[i] = jif.TDO;
            tick(i == 2, pin[i]);
        end
        for (int i = 0; i < 4; i++) tick(0, 0);
        check("pause_state",  64'(STATE), 64'h3);
        check("pause_tdo_en", 64'(jif.TDO_EN), 64'h0);
        tick(1, 0); tick(0, 0);
        for (int i = 3; i < BL; i++) begin
            pv[i] = jif.TDO;
            tick(i == BL - 1, pin[i]);
        end
        tick(1, 0); tick(0, 0);
        check("pause_cap", 64'(pv), 64'h15A);
        check("pause_upd", 64'(BSR_OUT), 64'h0F1);
        shift_dr(BL, 64'h0F1, dro);
        check("unbroken_cap", dro[BL-1:0], 64'(pv));

        // Reset in the middle of Shift-DR
        BSR_IN = 10'h3FF;
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1);
        TRST_N = 1'b0;
        model_reset();
        #1;
        check("trst_state",  64'(STATE),      64'hF);
        check("trst_bsr",    64'(BSR_OUT),    64'h0);
        check("trst_ir",     64'(IR_OUT),     64'h7);
        check("trst_tdo_en", 64'(jif.TDO_EN), 64'h0);
        @(negedge TCK); #2;
        TRST_N = 1'b1;
        tick(0, 0);

        // USERCODE
        shift_ir(4'h8, iro);
        shift_dr(32, 64'h0000_FFFF, dro);
`ifdef JTAG_USERCODE_EN
        check("usercode", dro[31:0], 64'h0000_00A5);
`else
        check("usercode_bypass", dro[31:0], 64'h0001_FFFE);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
